// File: rtl/swervolf_axi_sram_if.sv
// swervolf_axi_sram_if: AXI4 bus bundle between an initiator and the on-chip SRAM target
interface swervolf_axi_sram_if #(parameter int ID_WIDTH = 4);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [ID_WIDTH-1:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [63:0] wdata;
  logic [7:0] wstrb;
  logic wlast, wvalid, wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ID_WIDTH-1:0] rid;
  logic [63:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/swervolf_axi_sram.sv
// swervolf_axi_sram: single-transaction AXI4 responder over a 64-bit synchronous SRAM
module swervolf_axi_sram #(
  parameter int ID_WIDTH = 4,
  parameter int MEM_SIZE = 65536,
  parameter INIT_FILE = ""
) (
  input logic clk,
  input logic rst_n,
  swervolf_axi_sram_if.slave bus
);
  localparam int AW = $clog2(MEM_SIZE);
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, WRESP = 2'd2, READ = 2'd3;
  logic [1:0] st;
  logic last_rd, err, done;
  logic [ID_WIDTH-1:0] id;
  logic [31:0] addr, nxt, step, wmask;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic [1:0] burst;
  logic [63:0] mem [MEM_SIZE/8];
  logic [63:0] rbuf [2];
  logic [1:0] rlast_buf, occ;
  logic rp, wp, rv;
  logic idle, pick_ar, aw_hs, ar_hs, w_hs, b_hs, r_hs, issue;
  logic [ID_WIDTH-1:0] q_id;
  logic [31:0] q_addr;
  logic [7:0] q_len;
  logic [2:0] q_size;
  logic [1:0] q_burst;
  logic q_err;
  logic [AW-4:0] widx;
  assign idle = st == IDLE;
  assign pick_ar = (bus.arvalid ^ bus.awvalid) ? bus.arvalid : !last_rd;
  assign bus.arready = rst_n & idle & pick_ar;
  assign bus.awready = rst_n & idle & !pick_ar;
  assign aw_hs = bus.awvalid & bus.awready;
  assign ar_hs = bus.arvalid & bus.arready;
  assign w_hs = bus.wvalid & bus.wready;
  assign b_hs = bus.bvalid & bus.bready;
  assign r_hs = rv & bus.rready;
  assign bus.wready = st == WRITE;
  assign bus.bvalid = st == WRESP;
  assign bus.bid = id;
  assign bus.bresp = {err, 1'b0};
  assign rv = occ != 2'd0;
  assign bus.rvalid = rv;
  assign bus.rid = id;
  assign bus.rdata = rv ? rbuf[rp] : '0;
  assign bus.rlast = rv & rlast_buf[rp];
  assign bus.rresp = {err & rv, 1'b0};
  assign q_id = ar_hs ? bus.arid : bus.awid;
  assign q_addr = ar_hs ? bus.araddr : bus.awaddr;
  assign q_len = ar_hs ? bus.arlen : bus.awlen;
  assign q_size = ar_hs ? bus.arsize : bus.awsize;
  assign q_burst = ar_hs ? bus.arburst : bus.awburst;
  assign q_err = q_size > 3'd3 || (q_burst == 2'b10 && !(q_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign issue = st == READ && !done && (occ != 2'd2 || r_hs);
  assign widx = addr[AW-1:3];
  assign step = 32'd1 << size;
  assign wmask = ((32'(len) + 32'd1) << size) - 32'd1;
  assign nxt = burst == 2'b00 ? addr : burst == 2'b10 ? (addr & ~wmask) | ((addr + step) & wmask) : addr + step;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      last_rd <= 1'b0;
      err <= 1'b0;
      done <= 1'b0;
      id <= '0;
      addr <= '0;
      len <= '0;
      cnt <= '0;
      size <= '0;
      burst <= '0;
      rlast_buf <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      occ <= '0;
    end else begin
      if (aw_hs || ar_hs) begin
        st <= ar_hs ? READ : WRITE;
        id <= q_id;
        addr <= q_addr;
        len <= q_len;
        size <= q_size;
        burst <= q_burst;
        err <= q_err;
        cnt <= '0;
        done <= 1'b0;
      end
      if (w_hs) begin
        addr <= nxt;
        cnt <= cnt + 8'd1;
        if (cnt == len) st <= WRESP;
      end
      if (b_hs) begin
        st <= IDLE;
        last_rd <= 1'b0;
      end
      if (issue) begin
        addr <= nxt;
        cnt <= cnt + 8'd1;
        done <= cnt == len;
        rlast_buf[wp] <= cnt == len;
        wp <= !wp;
      end
      if (r_hs) begin
        rp <= !rp;
        if (bus.rlast) begin
          st <= IDLE;
          last_rd <= 1'b1;
        end
      end
      occ <= occ + 2'(issue) - 2'(r_hs);
    end
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < 8; b++)
      if (w_hs && !err && bus.wstrb[b]) mem[widx][8*b +: 8] <= bus.wdata[8*b +: 8];
    if (issue) rbuf[wp] <= err ? '0 : mem[widx];
  end
endmodule
